wb_port_arbiter: RTL

//  Shares the single register-file write port between the ALU result path and
//  the load-data return path. Each source hands over {rd, data} via valid/ready

---
 rtl/wb_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU and load sources each feed a one-entry
// holding register; one held entry per cycle is written, load first, ALU forced through after MAX_WAIT losses.
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              alu_pend,
    output logic              ld_pend
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [0:0] {LD_PRI, ALU_PRI} prio_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_LD, GNT_ALU} gnt_t;

    prio_t             state;
    prio_t             state_next;
    gnt_t              gnt;

    logic              alu_pend_q;
    logic [ADDR_W-1:0] alu_rd_q;
    logic [DATA_W-1:0] alu_data_q;
    logic              ld_pend_q;
    logic [ADDR_W-1:0] ld_rd_q;
    logic [DATA_W-1:0] ld_data_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_next;

    logic              alu_req;
    logic              ld_req;
    logic              alu_drop;
    logic              ld_drop;
    logic              alu_retire;
    logic              ld_retire;

    // Writes to x0 are meaningless: such entries are discarded instead of granted.
    assign alu_req  = alu_pend_q && (alu_rd_q != '0);
    assign ld_req   = ld_pend_q  && (ld_rd_q  != '0);
    assign alu_drop = alu_pend_q && (alu_rd_q == '0);
    assign ld_drop  = ld_pend_q  && (ld_rd_q  == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LD_PRI;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    always_comb begin
        gnt        = GNT_NONE;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wait_next  = wait_cnt;
        state_next = LD_PRI;

        // Same destination on both sides: the load is older and must land first.
        if (alu_req && ld_req) begin
            if ((state == ALU_PRI) && (alu_rd_q != ld_rd_q)) begin
                gnt = GNT_ALU;
            end else begin
                gnt = GNT_LD;
            end
        end else if (ld_req) begin
            gnt = GNT_LD;
        end else if (alu_req) begin
            gnt = GNT_ALU;
        end

        case (gnt)
            GNT_LD: begin
                wr_en   = 1'b1;
                wr_addr = ld_rd_q;
                wr_data = ld_data_q;
            end
            GNT_ALU: begin
                wr_en   = 1'b1;
                wr_addr = alu_rd_q;
                wr_data = alu_data_q;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase

        alu_retire = alu_drop || (gnt == GNT_ALU);
        ld_retire  = ld_drop  || (gnt == GNT_LD);

        if (alu_retire) begin
            wait_next = '0;
        end else if (alu_req && (wait_cnt != WAIT_MAX)) begin
            wait_next = wait_cnt + 1'b1;
        end

        if (wait_next == WAIT_MAX) begin
            state_next = ALU_PRI;
        end
    end

    // A retiring entry frees its slot in the same cycle so a source can stream.
    assign alu_ready = !alu_pend_q || alu_retire;
    assign ld_ready  = !ld_pend_q  || ld_retire;
    assign alu_pend  = alu_pend_q;
    assign ld_pend   = ld_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_pend_q <= 1'b0;
            alu_rd_q   <= '0;
            alu_data_q <= '0;
        end else if (alu_valid && alu_ready) begin
            alu_pend_q <= 1'b1;
            alu_rd_q   <= alu_rd;
            alu_data_q <= alu_data;
        end else if (alu_retire) begin
            alu_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pend_q <= 1'b0;
            ld_rd_q   <= '0;
            ld_data_q <= '0;
        end else if (ld_valid && ld_ready) begin
            ld_pend_q <= 1'b1;
            ld_rd_q   <= ld_rd;
            ld_data_q <= ld_data;
        end else if (ld_retire) begin
            ld_pend_q <= 1'b0;
        end
    end

endmodule
